// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin front end for a single-command SDRAM
// controller user interface. One access is in flight at a time; reads wait for
// the controller's c_out_valid or are aborted after TIMEOUT cycles.
//
// Ports:
//   clk, rst            - clock and synchronous active-low reset
//   pN_req/rw/addr/wdata - request from port N (held until pN_gnt)
//   pN_gnt               - one-cycle accept pulse (the write is complete here)
//   pN_rdata/pN_rvalid   - read return to port N
//   rd_err               - one-cycle pulse, read aborted by timeout
//   c_addr/c_rw/c_wdata/c_in_valid - command to the SDRAM controller
//   c_busy/c_rdata/c_out_valid     - status and read data from the controller
// Latency: grant one cycle after arbitration; read data one cycle after
// c_out_valid. Backpressure: c_busy=1 holds off arbitration in IDLE.

module sdram_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_rw,
  input  logic        p1_rw,
  input  logic [22:0] p0_addr,
  input  logic [22:0] p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic        rd_err,
  output logic [22:0] c_addr,
  output logic        c_rw,
  output logic [31:0] c_wdata,
  output logic        c_in_valid,
  input  logic        c_busy,
  input  logic [31:0] c_rdata,
  input  logic        c_out_valid
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    GAP     = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;       // 0 = port 0, 1 = port 1
  logic          last_gnt, last_gnt_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          winner;
  logic          arb_go;
  logic          rd_done;
  logic          rd_tmo;

  // Next-cycle values of the registered outputs.
  logic          c_in_valid_d;
  logic          p0_gnt_d, p1_gnt_d;
  logic          p0_rvalid_d, p1_rvalid_d;
  logic          rd_err_d;
  logic [31:0]   p0_rdata_d, p1_rdata_d;
  logic [22:0]   c_addr_d;
  logic          c_rw_d;
  logic [31:0]   c_wdata_d;

  // Round-robin pick: on a tie the port that was not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (p0_req && p1_req) begin
      winner = ~last_gnt;
    end else if (p1_req) begin
      winner = 1'b1;
    end
  end

  assign arb_go  = (state == IDLE) && !c_busy && (p0_req || p1_req);
  assign rd_done = (state == RD_WAIT) && c_out_valid;
  // Data return takes priority over expiry when both land on the same cycle.
  assign rd_tmo  = (state == RD_WAIT) && !c_out_valid && (cnt == CW'(TIMEOUT - 1));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_gnt   <= 1'b1;
      cnt        <= '0;
      c_in_valid <= 1'b0;
      c_rw       <= 1'b0;
      c_addr     <= '0;
      c_wdata    <= '0;
      p0_gnt     <= 1'b0;
      p1_gnt     <= 1'b0;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      rd_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_gnt   <= last_gnt_nxt;
      cnt        <= cnt_nxt;
      c_in_valid <= c_in_valid_d;
      c_rw       <= c_rw_d;
      c_addr     <= c_addr_d;
      c_wdata    <= c_wdata_d;
      p0_gnt     <= p0_gnt_d;
      p1_gnt     <= p1_gnt_d;
      p0_rvalid  <= p0_rvalid_d;
      p1_rvalid  <= p1_rvalid_d;
      p0_rdata   <= p0_rdata_d;
      p1_rdata   <= p1_rdata_d;
      rd_err     <= rd_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_go) state_nxt = ISSUE;
      ISSUE:   state_nxt = GAP;
      // GAP covers the controller's one-cycle busy latency after c_in_valid.
      GAP:     state_nxt = c_rw ? IDLE : RD_WAIT;
      RD_WAIT: if (rd_done || rd_tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: computes the values the output registers take next cycle.
  always_comb begin
    c_in_valid_d = 1'b0;
    p0_gnt_d     = 1'b0;
    p1_gnt_d     = 1'b0;
    p0_rvalid_d  = 1'b0;
    p1_rvalid_d  = 1'b0;
    rd_err_d     = 1'b0;
    p0_rdata_d   = p0_rdata;
    p1_rdata_d   = p1_rdata;
    c_addr_d     = c_addr;
    c_rw_d       = c_rw;
    c_wdata_d    = c_wdata;
    owner_nxt    = owner;
    last_gnt_nxt = last_gnt;
    cnt_nxt      = cnt;
    case (state)
      IDLE: begin
        if (arb_go) begin
          owner_nxt    = winner;
          last_gnt_nxt = winner;
          c_rw_d       = winner ? p1_rw    : p0_rw;
          c_addr_d     = winner ? p1_addr  : p0_addr;
          c_wdata_d    = winner ? p1_wdata : p0_wdata;
          c_in_valid_d = 1'b1;
          p0_gnt_d     = ~winner;
          p1_gnt_d     = winner;
        end
      end
      GAP: begin
        // Counter starts from zero on the first RD_WAIT cycle.
        cnt_nxt = '0;
      end
      RD_WAIT: begin
        cnt_nxt = cnt + 1'b1;
        if (rd_done) begin
          if (owner) begin
            p1_rvalid_d = 1'b1;
            p1_rdata_d  = c_rdata;
          end else begin
            p0_rvalid_d = 1'b1;
            p0_rdata_d  = c_rdata;
          end
        end else if (rd_tmo) begin
          rd_err_d = 1'b1;
          if (owner) begin
            p1_rvalid_d = 1'b1;
            p1_rdata_d  = 32'h0;
          end else begin
            p0_rvalid_d = 1'b1;
            p0_rdata_d  = 32'h0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a time-based transaction model
// predicts every registered output each cycle, and directed scenarios add
// hand-computed literal expectations.
module tb_sdram_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_req = 0, p1_req = 0, p0_rw = 0, p1_rw = 0;
  logic [22:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rd_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [22:0] c_addr;
  logic        c_rw, c_in_valid;
  logic [31:0] c_wdata;
  logic        c_busy = 0, c_out_valid = 0;
  logic [31:0] c_rdata = '0;

  always #5 clk = ~clk;

  sdram_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p1_req(p1_req), .p0_rw(p0_rw), .p1_rw(p1_rw),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid), .rd_err(rd_err),
    .c_addr(c_addr), .c_rw(c_rw), .c_wdata(c_wdata), .c_in_valid(c_in_valid),
    .c_busy(c_busy), .c_rdata(c_rdata), .c_out_valid(c_out_valid)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction model (absolute cycle windows) ----------------
  int  cyc = 0, free_at = 0, rd_first = 0, rd_last = 0;
  bit  rd_on = 0, m_owner = 0, m_last = 1, mdl_ok = 0;
  logic        e_gnt0 = 0, e_gnt1 = 0, e_inv = 0, e_rv0 = 0, e_rv1 = 0, e_err = 0, e_rw = 0;
  logic [22:0] e_addr = '0;
  logic [31:0] e_wdata = '0, e_rd0 = '0, e_rd1 = '0;

  always @(posedge clk) begin
    cyc++;
    e_gnt0 = 0; e_gnt1 = 0; e_inv = 0; e_rv0 = 0; e_rv1 = 0; e_err = 0;
    if (!rst) begin
      mdl_ok = 1; rd_on = 0; m_last = 1; free_at = cyc + 1;
      e_rw = 0; e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    end else if (rd_on) begin
      // A read owns the block from grant until data or expiry.
      if (cyc >= rd_first && c_out_valid) begin
        if (m_owner) begin e_rv1 = 1; e_rd1 = c_rdata; end
        else         begin e_rv0 = 1; e_rd0 = c_rdata; end
        rd_on = 0; free_at = cyc + 1;
      end else if (cyc == rd_last) begin
        e_err = 1;
        if (m_owner) begin e_rv1 = 1; e_rd1 = 32'h0; end
        else         begin e_rv0 = 1; e_rd0 = 32'h0; end
        rd_on = 0; free_at = cyc + 1;
      end
    end else if (cyc >= free_at && !c_busy && (p0_req || p1_req)) begin
      m_owner = (p0_req && p1_req) ? !m_last : p1_req;
      m_last  = m_owner;
      e_rw    = m_owner ? p1_rw : p0_rw;
      e_addr  = m_owner ? p1_addr : p0_addr;
      e_wdata = m_owner ? p1_wdata : p0_wdata;
      e_inv   = 1;
      if (m_owner) e_gnt1 = 1; else e_gnt0 = 1;
      if (e_rw) free_at = cyc + 3;
      else begin rd_on = 1; rd_first = cyc + 3; rd_last = cyc + 2 + TO; end
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("p0_gnt",     32'(p0_gnt),     32'(e_gnt0));
      chk("p1_gnt",     32'(p1_gnt),     32'(e_gnt1));
      chk("p0_rvalid",  32'(p0_rvalid),  32'(e_rv0));
      chk("p1_rvalid",  32'(p1_rvalid),  32'(e_rv1));
      chk("p0_rdata",   p0_rdata,        e_rd0);
      chk("p1_rdata",   p1_rdata,        e_rd1);
      chk("rd_err",     32'(rd_err),     32'(e_err));
      chk("c_in_valid", 32'(c_in_valid), 32'(e_inv));
      chk("c_rw",       32'(c_rw),       32'(e_rw));
      chk("c_addr",     32'(c_addr),     32'(e_addr));
      chk("c_wdata",    c_wdata,         e_wdata);
    end
  end

  // ---------------- stimulus: requesters and controller responder ----------------
  int resp_cd = 0, resp_delay = 2, rn = 0;
  bit resp_en = 0, auto0 = 0, auto1 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (p0_gnt) begin if (auto0) p0_addr = p0_addr + 1; else p0_req = 0; end
    if (p1_gnt) begin if (auto1) p1_addr = p1_addr + 1; else p1_req = 0; end
    c_out_valid = 0;
    if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) begin
        c_out_valid = 1;
        c_rdata = 32'h1111_0000 + 32'(rn);
        rn++;
      end
    end
    if (resp_en && c_in_valid && !c_rw) resp_cd = resp_delay;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0, t1, tg, te, n_inv, k, rv_idx;
    bit seen, got, any;
    int gseq[$];

    // Reset
    rst = 0;
    repeat (3) tick();
    chk("rst_c_in_valid", 32'(c_in_valid), 0);
    chk("rst_gnt",        32'({p0_gnt, p1_gnt}), 0);
    chk("rst_rvalid",     32'({p0_rvalid, p1_rvalid, rd_err}), 0);
    chk("rst_c_addr",     32'(c_addr), 0);
    rst = 1;
    tick();

    // p0 write and p1 read arrive together: first tie goes to p0
    resp_en = 1; resp_delay = 2; rn = 0;
    p0_rw = 1; p0_addr = 23'h000104; p0_wdata = 32'hA5A5_0001; p0_req = 1;
    p1_rw = 0; p1_addr = 23'h000200; p1_req = 1;
    t0 = -100; t1 = 0; n_inv = 0; seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (c_in_valid) n_inv++;
      if (c_in_valid && !seen) begin
        seen = 1; t0 = i;
        chk("wr_c_addr",  32'(c_addr), 32'h000104);
        chk("wr_c_rw",    32'(c_rw), 1);
        chk("wr_c_wdata", c_wdata, 32'hA5A5_0001);
        chk("wr_p0_gnt",  32'(p0_gnt), 1);
        chk("wr_p1_gnt",  32'(p1_gnt), 0);
      end
      if (p1_gnt) t1 = i;
      if (p1_rvalid) chk("rd1_data", p1_rdata, 32'h1111_0000);
    end
    chk("wr_to_next_gnt", 32'(t1 - t0), 3);
    chk("issue_cycles",   32'(n_inv), 2);

    // Both ports reading back-to-back: grants alternate, data follows owner
    resp_delay = 3; rn = 0; rv_idx = 0;
    p0_rw = 0; p1_rw = 0; auto0 = 1; auto1 = 1; p0_req = 1; p1_req = 1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (p0_gnt) gseq.push_back(0);
      if (p1_gnt) gseq.push_back(1);
      if (gseq.size() >= 6) begin auto0 = 0; auto1 = 0; end
      if (p0_rvalid || p1_rvalid) begin
        chk("rr_rv_port", 32'(p1_rvalid), 32'(rv_idx % 2));
        chk("rr_rdata", p1_rvalid ? p1_rdata : p0_rdata, 32'h1111_0000 + 32'(rv_idx));
        rv_idx++;
      end
    end
    chk("rr_n_gnt", 32'(gseq.size() >= 6), 1);
    foreach (gseq[i]) chk("rr_gnt_order", 32'(gseq[i]), 32'(i % 2));
    chk("rr_n_rvalid", 32'(rv_idx), 32'(gseq.size()));

    // p1 read with no response: timeout
    resp_en = 0; p1_addr = 23'h000333; p1_req = 1;
    tg = -100; te = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (p1_gnt) tg = i;
      if (rd_err) begin
        te = i;
        chk("tmo_p1_rvalid", 32'(p1_rvalid), 1);
        chk("tmo_p1_rdata",  p1_rdata, 32'h0);
        chk("tmo_p0_rvalid", 32'(p0_rvalid), 0);
      end
    end
    chk("tmo_latency", 32'(te - tg), 10);
    p0_rw = 1; p0_addr = 23'h000044; p0_wdata = 32'h0000_BEEF; p0_req = 1;
    got = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (p0_gnt) got = 1; end
    chk("post_tmo_gnt", 32'(got), 1);

    // Stray c_out_valid while idle is ignored
    c_out_valid = 1; c_rdata = 32'hDEAD_0001;
    tick();
    chk("stray_rvalid", 32'({p0_rvalid, p1_rvalid}), 0);

    // Controller busy: no grant, p1 drops its request before grant
    c_busy = 1; p0_addr = 23'h000055; p0_wdata = 32'h5555_0000; p0_req = 1; p1_req = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) p1_req = 0;
      chk("busy_c_in_valid", 32'(c_in_valid), 0);
      chk("busy_p0_gnt",     32'(p0_gnt), 0);
    end
    c_busy = 0;
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("busy_p1_gnt", 32'(p1_gnt), 0);
      if (p0_gnt && k == 0) k = i;
    end
    chk("busy_release_lat", 32'(k), 1);

    // Reset in the middle of a read, then a late c_out_valid
    p0_rw = 0; p0_addr = 23'h000066; p0_req = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin tick(); if (p0_gnt) got = 1; end
    chk("mid_rst_gnt", 32'(got), 1);
    repeat (4) tick();
    rst = 0;
    tick();
    rst = 1;
    chk("mid_rst_p0_rdata", p0_rdata, 0);
    chk("mid_rst_p1_rdata", p1_rdata, 0);
    chk("mid_rst_c_wdata",  c_wdata, 0);
    chk("mid_rst_c_addr",   32'(c_addr), 0);
    chk("mid_rst_flags",    32'({c_rw, c_in_valid, rd_err, p0_rvalid, p1_rvalid}), 0);
    c_out_valid = 1; c_rdata = 32'hDEAD_0002;
    any = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (p0_rvalid || p1_rvalid || rd_err) any = 1;
    end
    chk("mid_rst_no_rvalid", 32'(any), 0);

    // Data arrives on the same cycle the timeout expires: data wins
    resp_en = 1; resp_delay = 9; rn = 0;
    p1_rw = 0; p1_addr = 23'h000777; p1_req = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (p1_rvalid) begin
        seen = 1;
        chk("edge_rd_err", 32'(rd_err), 0);
        chk("edge_rdata",  p1_rdata, 32'h1111_0000);
      end
    end
    chk("edge_rvalid_seen", 32'(seen), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 64: maximum cycles spent in RD_WAIT before a read is aborted.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-004 SHALL have ports p0_req, p1_req, input, 1: access request from port N, held high until pN_gnt.
REQ-005 SHALL have ports p0_rw, p1_rw, input, 1: 1 = write, 0 = read; stable while pN_req is high.
REQ-006 SHALL have ports p0_addr, p1_addr, input, 23: user address; stable while pN_req is high.
REQ-007 SHALL have ports p0_wdata, p1_wdata, input, 32: write data; stable while pN_req is high.
REQ-008 SHALL have ports p0_gnt, p1_gnt, output, 1: one-cycle pulse, request accepted.
REQ-009 SHALL have ports p0_rdata, p1_rdata, output, 32: read return data.
REQ-010 SHALL have ports p0_rvalid, p1_rvalid, output, 1: one-cycle pulse, pN_rdata valid.
REQ-011 SHALL have port rd_err, output, 1: one-cycle pulse, read aborted by timeout.
REQ-012 SHALL have ports c_addr (output, 23), c_rw (output, 1), c_wdata (output, 32) and c_in_valid (output, 1): request side of the SDRAM controller user interface.
REQ-013 SHALL have ports c_busy (input, 1), c_rdata (input, 32) and c_out_valid (input, 1): response side of the SDRAM controller user interface.

Function
REQ-014 SHALL implement the states IDLE, ISSUE, GAP and RD_WAIT; all outputs SHALL be registered.
REQ-015 IDLE: when c_busy=0 and any pN_req=1, the block SHALL pick a winner, latch its rw/addr/wdata into c_rw/c_addr/c_wdata, record the owner, and go to ISSUE.
REQ-016 IDLE: when c_busy=1, the block SHALL not arbitrate; requests SHALL wait with no grant.
REQ-017 Arbitration SHALL be round-robin.
- A single requester wins outright.
- If both request, the port not granted last wins.
- last_gnt SHALL reset to 1, so port 0 wins the first tie.
REQ-018 ISSUE (exactly 1 cycle): c_in_valid=1 and owner pN_gnt=1; next state GAP.
REQ-019 GAP (exactly 1 cycle, absorbs the controller's one-cycle busy latency): c_in_valid=0; next state RD_WAIT if c_rw=0, else IDLE.
REQ-020 c_addr, c_rw and c_wdata SHALL hold their latched values until the next arbitration.
REQ-021 RD_WAIT: on c_out_valid=1, the next cycle SHALL give owner pN_rdata=c_rdata and pN_rvalid=1; the other port's rdata/rvalid SHALL be unchanged/0; next state IDLE.
REQ-022 RD_WAIT timeout counter:
- cleared on entry, increments each cycle.
- on reaching TIMEOUT-1 without c_out_valid, the next cycle SHALL give rd_err=1, owner pN_rvalid=1 and pN_rdata=32'h0; next state IDLE.
REQ-023 If c_out_valid coincides with timeout expiry, the data return (REQ-021) SHALL win and rd_err SHALL stay 0.
REQ-024 c_out_valid outside RD_WAIT SHALL be ignored: no rvalid, no state change.
REQ-025 At most one read SHALL be outstanding; no issue SHALL occur from RD_WAIT.
REQ-026 A write SHALL complete from the requester's view at pN_gnt; no write acknowledge SHALL be given.
REQ-027 Write-to-next-request turnaround SHALL be a minimum of 3 cycles (IDLE-ISSUE-GAP), and longer while c_busy=1.
REQ-028 A request dropped before grant SHALL be legal and SHALL not be granted.

Reset
REQ-029 While rst=0 at a clock edge, the block SHALL reset as follows:
- state=IDLE, last_gnt=1, timeout counter=0.
- c_in_valid=0, c_rw=0, c_addr=0, c_wdata=0.
- pN_gnt=0, pN_rvalid=0, pN_rdata=0, rd_err=0.
REQ-030 Reset mid-operation SHALL discard any pending read with no rvalid; a late c_out_valid after reset SHALL be ignored per REQ-024.

Verification
REQ-031 p0 write addr 23'h000104, data 32'hA5A5_0001, c_busy=0 -> c_in_valid 1 cycle with c_addr=23'h000104, c_rw=1, c_wdata=32'hA5A5_0001; p0_gnt same cycle; back in IDLE 2 cycles later.
REQ-032 p0 and p1 reads every cycle from reset, controller returns c_rdata=32'h1111_0000+n -> grants alternate p0,p1,p0,p1; each rvalid goes to the matching port with its data.
REQ-033 p1 read, c_out_valid never asserted, TIMEOUT=8 -> rd_err and p1_rvalid pulse together with p1_rdata=0, then IDLE; a subsequent p0 request is granted.
REQ-034 c_busy held 1 for 10 cycles with p0_req=1 -> no p0_gnt and c_in_valid=0 throughout; grant issued the cycle after c_busy falls plus one.
REQ-035 rst=0 pulsed during RD_WAIT, then c_out_valid=1 -> all outputs at reset values; no rvalid on either port.
REQ-036 c_out_valid in the same cycle as timeout expiry -> rvalid with c_rdata, rd_err=0.
